// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and source indices for the arbitrated bus
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } bus_state_t;

  localparam int DEF_DATA_W = 32;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search starting at ptr
module rr_arbiter #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   winner
);

  int idx;

  // Walk offsets from the far end down so the smallest offset from ptr is the last writer.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - round-robin arbitrated, registered shared-bus multiplexer
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_SRC  = 24,
  parameter int MAX_HOLD = 4,
  parameter int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic                        lock,
  output logic [NUM_SRC-1:0]          src_gnt,
  output logic [DATA_W-1:0]           bus_out,
  output logic                        bus_valid,
  output logic [SEL_W-1:0]            bus_owner
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  bus_state_t          state, state_nx;
  logic [SEL_W-1:0]    ptr, ptr_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic [NUM_SRC-1:0]  gnt_nx;
  logic [DATA_W-1:0]   bus_nx;
  logic                valid_nx;
  logic [SEL_W-1:0]    owner_nx;

  logic [NUM_SRC-1:0]  cand;
  logic                arb_valid;
  logic [SEL_W-1:0]    arb_winner;
  logic                owner_req;
  logic [DATA_W-1:0]   owner_data;
  logic [DATA_W-1:0]   win_data;
  logic                do_grant;
  logic                go_idle;

  // The current owner never competes against itself; in IDLE src_gnt is zero so all requests compete.
  assign cand       = src_req & ~src_gnt;
  assign owner_req  = |(src_req & src_gnt);
  assign owner_data = src_data[int'(bus_owner)*DATA_W +: DATA_W];
  assign win_data   = src_data[int'(arb_winner)*DATA_W +: DATA_W];

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_rr_arbiter (
    .req    (cand),
    .ptr    (ptr),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Next-state: grant a new owner, drop to idle, or keep the owner and refresh its data.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    gnt_nx   = src_gnt;
    bus_nx   = bus_out;
    valid_nx = bus_valid;
    owner_nx = bus_owner;
    do_grant = 1'b0;
    go_idle  = 1'b0;

    case (state)
      IDLE: begin
        if (arb_valid) do_grant = 1'b1;
        else           go_idle  = 1'b1;
      end
      OWNED: begin
        if (!owner_req) begin
          if (arb_valid) do_grant = 1'b1;
          else           go_idle  = 1'b1;
        end else if (!lock && (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && arb_valid) begin
          do_grant = 1'b1;
        end else begin
          bus_nx = owner_data;
          if (hold_cnt < HOLD_MAX) hold_nx = hold_cnt + 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_nx = OWNED;
      gnt_nx   = NUM_SRC'(1) << arb_winner;
      owner_nx = arb_winner;
      bus_nx   = win_data;
      valid_nx = 1'b1;
      hold_nx  = HOLD_W'(1);
      ptr_nx   = (int'(arb_winner) == NUM_SRC - 1) ? '0 : arb_winner + SEL_W'(1);
    end

    if (go_idle) begin
      state_nx = IDLE;
      gnt_nx   = '0;
      bus_nx   = '0;
      valid_nx = 1'b0;
      hold_nx  = '0;
    end
  end

  // State, arbitration bookkeeping and the registered bus outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      src_gnt   <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      bus_owner <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      src_gnt   <= gnt_nx;
      bus_out   <= bus_nx;
      bus_valid <= valid_nx;
      bus_owner <= owner_nx;
    end
  end

endmodule
